// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path: scheduler state encoding and the default byte width.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational head read. A write is accepted into a full FIFO
// only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: buffers received bytes and hands them to uart_tx one at a time,
// only while the transmitter is idle.
//
// state     | meaning
// IDLE      | waiting for a queued byte with tx_busy low
// ISSUE     | tx_en strobe cycle, ack timer loaded
// WAIT_ACK  | waiting for tx_busy to rise, ack timer running
// WAIT_DONE | frame in flight, waiting for tx_busy to fall
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACK_TMO = 15
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   rx_done,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   tx_busy,
  input  logic                   ovf_clr,
  output logic                   tx_en,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int TW = $clog2(ACK_TMO + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TMO);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  tx_state_e         state;
  tx_state_e         state_nxt;
  logic [TW-1:0]     ack_tmr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              drop;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (rx_done),
    .wr_data   (rx_data),
    .rd_en     (fifo_pop),
    .rd_data   (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_pop = (state == IDLE) && !fifo_empty && !tx_busy;
  assign drop     = rx_done && fifo_full && !fifo_pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fifo_pop) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy)             state_nxt = WAIT_DONE;
        else if (ack_tmr == '0)  state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      tx_en <= (state_nxt == ISSUE);
      if (fifo_pop) tx_data <= head_data;
    end
  end

  // Down-counter: loaded during the strobe, expires ACK_TMO cycles into WAIT_ACK.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_tmr <= '0;
    end else if (state == ISSUE) begin
      ack_tmr <= TMO_LOAD;
    end else if ((state == WAIT_ACK) && (ack_tmr != '0)) begin
      ack_tmr <= ack_tmr - TMR_ONE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a simple uart_tx busy model.
module tb_uart_tx_sched;

  localparam int DEPTH   = 16;
  localparam int DATA_W  = 8;
  localparam int ACK_TMO = 15;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              rx_done   = 1'b0;
  logic [DATA_W-1:0] rx_data   = '0;
  logic              tx_busy   = 1'b0;
  logic              ovf_clr   = 1'b0;
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic [CW-1:0]     fifo_count;
  logic              overflow;

  always #5 sys_clk = ~sys_clk;

  uart_tx_sched #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .ACK_TMO (ACK_TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .ovf_clr    (ovf_clr),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, tx_cnt = 0, tx_cyc_prev = 0, tx_cyc_last = 0, fall_cyc = 0;
  int busy_left = 0, frame_len = 20, busy_mode = 0, peak = 0, base = 0;
  bit gap_chk = 1'b0;
  logic [DATA_W-1:0] sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: release pulses after the edge, then monitor and busy model at the negedge.
  // busy_mode 0: busy high frame_len cycles after each tx_en; 1: held high; 2: held low.
  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    #1;
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    @(negedge sys_clk);
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    if (tx_en === 1'b1) begin
      tx_cnt++;
      tx_cyc_prev = tx_cyc_last;
      tx_cyc_last = cyc;
      check_val("tx_while_busy", 32'(tx_busy), 32'd0);
      if (gap_chk) check_val("gap_after_busy_fall", 32'((cyc - fall_cyc) >= 2), 32'd1);
      if (sb_q.size() == 0) check_val("sb_size_at_tx", 32'(sb_q.size()), 32'd1);
      else check_val("tx_data", 32'(tx_data), 32'(sb_q.pop_front()));
    end
    case (busy_mode)
      0: begin
        if (tx_en === 1'b1) begin
          busy_left = frame_len;
          tx_busy   = 1'b1;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            tx_busy  = 1'b0;
            fall_cyc = cyc;
          end
        end
      end
      1: tx_busy = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit accept);
    rx_data = d;
    rx_done = 1'b1;
    if (accept) sb_q.push_back(d);
    tick();
  endtask

  task automatic wait_tx(input int target, input int limit, input string tag);
    for (int i = 0; i < limit && tx_cnt < target; i++) tick();
    check_val(tag, 32'(tx_cnt), 32'(target));
  endtask

  initial begin
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    check_val("rst_tx_en", 32'(tx_en), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);

    // single byte: count 1 in N+1, strobe in N+2
    frame_len = 20;
    base = tx_cnt;
    send(8'hA5, 1'b1);
    check_val("single_count_n1", 32'(fifo_count), 32'd1);
    check_val("single_tx_en_n1", 32'(tx_en), 32'd0);
    tick();
    check_val("single_tx_en_n2", 32'(tx_en), 32'd1);
    check_val("single_count_n2", 32'(fifo_count), 32'd0);
    repeat (40) tick();
    check_val("single_one_strobe", 32'(tx_cnt - base), 32'd1);

    // burst of 5 with long frames
    frame_len = 100;
    gap_chk = 1'b1;
    peak = 0;
    base = tx_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    wait_tx(base + 5, 700, "burst_tx_count");
    check_val("burst_peak", 32'(peak), 32'd4);
    check_val("burst_sb_empty", 32'(sb_q.size()), 32'd0);
    gap_chk = 1'b0;
    repeat (110) tick();

    // overflow with transmitter held busy
    busy_mode = 1;
    repeat (2) tick();
    for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i), 1'b1);
    check_val("ovf_before_drop", 32'(overflow), 32'd0);
    send(8'hEE, 1'b0);
    check_val("ovf_count_full", 32'(fifo_count), 32'd16);
    check_val("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    check_val("ovf_cleared", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    send(8'hEF, 1'b0);
    check_val("ovf_set_wins", 32'(overflow), 32'd1);
    check_val("ovf_count_still_full", 32'(fifo_count), 32'd16);
    ovf_clr = 1'b1;
    tick();
    check_val("ovf_cleared_again", 32'(overflow), 32'd0);

    // full FIFO, busy falls, write in the pop cycle
    busy_mode = 0;
    busy_left = 0;
    tx_busy   = 1'b0;
    frame_len = 5;
    base = tx_cnt;
    send(8'h77, 1'b1);
    check_val("fullpop_count", 32'(fifo_count), 32'd16);
    check_val("fullpop_overflow", 32'(overflow), 32'd0);
    wait_tx(base + 17, 400, "fullpop_drain");
    check_val("fullpop_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (20) tick();

    // ack timeout with busy stuck low
    busy_mode = 2;
    tick();
    base = tx_cnt;
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b1);
    wait_tx(base + 2, 100, "tmo_tx_count");
    check_val("tmo_spacing", 32'(tx_cyc_last - tx_cyc_prev), 32'(ACK_TMO + 3));
    repeat (ACK_TMO + 5) tick();

    // reset mid-frame with 3 bytes queued
    busy_mode = 0;
    frame_len = 50;
    tick();
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i), 1'b1);
    repeat (3) tick();
    check_val("midrst_count_before", 32'(fifo_count), 32'd3);
    sys_rst_n = 1'b0;
    #1;
    check_val("midrst_tx_en", 32'(tx_en), 32'd0);
    check_val("midrst_tx_data", 32'(tx_data), 32'd0);
    check_val("midrst_count", 32'(fifo_count), 32'd0);
    check_val("midrst_overflow", 32'(overflow), 32'd0);
    sb_q.delete();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    base = tx_cnt;
    send(8'h3C, 1'b1);
    repeat (10) tick();
    check_val("midrst_hold_while_busy", 32'(tx_cnt), 32'(base));
    wait_tx(base + 1, 100, "midrst_new_tx");
    check_val("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
